m_wb_stage: RTL and testbench

M_WB_STAGE -- requirements
Module: m_wb_stage

---
 rtl/m_wb_stage.sv | 82 ++++++++
 tb/tb_m_wb_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/m_wb_stage.sv
// m_wb_stage: M->WB pipeline register carrying result, PC, exception info and ROB tag.
// Latency: exactly one cycle, every output straight from a flop; sync active-low reset clears all.
// Backpressure: none by default; define M_WB_STAGE_STALL_EN to add a stall input that freezes the register.
module m_wb_stage #(
  parameter int WORD_SIZE = 32,
  parameter int ROB_ID_W  = 7
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef M_WB_STAGE_STALL_EN
  input  logic                 stall,
`endif
  input  logic [1:0]           instruction_type,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic                 exception,
  input  logic [WORD_SIZE-1:0] virtual_addr_exception,
  input  logic [WORD_SIZE-1:0] aluResult,
  input  logic [ROB_ID_W-1:0]  rob_id,
  input  logic                 valid,
  output logic [1:0]           instruction_type_out,
  output logic [WORD_SIZE-1:0] pc_out,
  output logic                 exception_out,
  output logic [WORD_SIZE-1:0] virtual_addr_exception_out,
  output logic [WORD_SIZE-1:0] aluResult_out,
  output logic [ROB_ID_W-1:0]  rob_id_out,
  output logic                 valid_out
);

  typedef struct packed {
    logic [1:0]           instruction_type;
    logic [WORD_SIZE-1:0] pc;
    logic                 exception;
    logic [WORD_SIZE-1:0] virtual_addr_exception;
    logic [WORD_SIZE-1:0] aluResult;
    logic [ROB_ID_W-1:0]  rob_id;
    logic                 valid;
  } wb_t;

  wb_t wb_q;
  wb_t wb_d;
  logic hold;

`ifdef M_WB_STAGE_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // Next state: hold current contents while stalled, otherwise capture the M-stage slot.
  // Payload is captured even for invalid slots; only the exception flag is qualified so a
  // bubble can never present an exception downstream.
  always_comb begin
    wb_d = wb_q;
    if (!hold) begin
      wb_d.instruction_type       = instruction_type;
      wb_d.pc                     = pc;
      wb_d.exception              = exception & valid;
      wb_d.virtual_addr_exception = virtual_addr_exception;
      wb_d.aluResult              = aluResult;
      wb_d.rob_id                 = rob_id;
      wb_d.valid                  = valid;
    end
  end

  // State register: reset wins over stall and data, discarding any in-flight instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign instruction_type_out       = wb_q.instruction_type;
  assign pc_out                     = wb_q.pc;
  assign exception_out              = wb_q.exception;
  assign virtual_addr_exception_out = wb_q.virtual_addr_exception;
  assign aluResult_out              = wb_q.aluResult;
  assign rob_id_out                 = wb_q.rob_id;
  assign valid_out                  = wb_q.valid;

endmodule

// File: tb/tb_m_wb_stage.sv
// tb_m_wb_stage: scoreboard bench for the M->WB pipeline register.
// Expected WB contents are queued when a slot is driven and compared one edge later.
// Stall sequences are exercised only when M_WB_STAGE_STALL_EN is defined.
module tb_m_wb_stage;
  localparam int WS = 32;
  localparam int RW = 7;
`ifdef M_WB_STAGE_STALL_EN
  localparam bit STALL_EN_C = 1'b1;
`else
  localparam bit STALL_EN_C = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          stall_drv;
  logic [1:0]    instruction_type;
  logic [WS-1:0] pc;
  logic          exception;
  logic [WS-1:0] virtual_addr_exception;
  logic [WS-1:0] aluResult;
  logic [RW-1:0] rob_id;
  logic          valid;
  logic [1:0]    instruction_type_out;
  logic [WS-1:0] pc_out;
  logic          exception_out;
  logic [WS-1:0] virtual_addr_exception_out;
  logic [WS-1:0] aluResult_out;
  logic [RW-1:0] rob_id_out;
  logic          valid_out;

  always #5 clk = ~clk;

  m_wb_stage #(.WORD_SIZE(WS), .ROB_ID_W(RW)) dut (
    .clk                        (clk),
    .reset                      (reset),
`ifdef M_WB_STAGE_STALL_EN
    .stall                      (stall_drv),
`endif
    .instruction_type           (instruction_type),
    .pc                         (pc),
    .exception                  (exception),
    .virtual_addr_exception     (virtual_addr_exception),
    .aluResult                  (aluResult),
    .rob_id                     (rob_id),
    .valid                      (valid),
    .instruction_type_out       (instruction_type_out),
    .pc_out                     (pc_out),
    .exception_out              (exception_out),
    .virtual_addr_exception_out (virtual_addr_exception_out),
    .aluResult_out              (aluResult_out),
    .rob_id_out                 (rob_id_out),
    .valid_out                  (valid_out)
  );

  typedef struct packed {
    logic          vld;
    logic          exc;
    logic [1:0]    typ;
    logic [WS-1:0] pc;
    logic [WS-1:0] va;
    logic [WS-1:0] alu;
    logic [RW-1:0] rob;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp = '0;
  exp_t cur_exp;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_eq({tag, ".valid_out"}, 64'(valid_out), 64'(e.vld));
    check_eq({tag, ".exception_out"}, 64'(exception_out), 64'(e.exc));
    check_eq({tag, ".instruction_type_out"}, 64'(instruction_type_out), 64'(e.typ));
    check_eq({tag, ".pc_out"}, 64'(pc_out), 64'(e.pc));
    check_eq({tag, ".virtual_addr_exception_out"}, 64'(virtual_addr_exception_out), 64'(e.va));
    check_eq({tag, ".aluResult_out"}, 64'(aluResult_out), 64'(e.alu));
    check_eq({tag, ".rob_id_out"}, 64'(rob_id_out), 64'(e.rob));
  endtask

  // Drive one slot and queue what WB must show after the next edge.
  task automatic drive(input logic rst, input logic stl, input logic vld, input logic [1:0] typ,
                       input logic [WS-1:0] p, input logic exc, input logic [WS-1:0] va,
                       input logic [WS-1:0] alu, input logic [RW-1:0] rob);
    exp_t e;
    reset                  = rst;
    stall_drv              = stl;
    valid                  = vld;
    instruction_type       = typ;
    pc                     = p;
    exception              = exc;
    virtual_addr_exception = va;
    aluResult              = alu;
    rob_id                 = rob;
    if (!rst) begin
      e = '0;
    end else if (STALL_EN_C && stl) begin
      e = last_exp;
    end else begin
      e.vld = vld;
      e.exc = exc && vld;
      e.typ = typ;
      e.pc  = p;
      e.va  = va;
      e.alu = alu;
      e.rob = rob;
    end
    last_exp = e;
    sb_q.push_back(e);
  endtask

  // Clock one edge, then pop the oldest expectation and compare.
  task automatic step_check(input string tag);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 64'd0, 64'd1);
      cur_exp = '0;
    end else begin
      cur_exp = sb_q.pop_front();
      check_outputs(tag, cur_exp);
    end
  endtask

  // Scramble inputs between edges; outputs must not move.
  task automatic perturb_check(input string tag);
    valid                  = ~valid;
    exception              = ~exception;
    instruction_type       = ~instruction_type;
    pc                     = $urandom;
    virtual_addr_exception = $urandom;
    aluResult              = $urandom;
    rob_id                 = RW'($urandom);
    #2;
    check_outputs(tag, cur_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for two edges with a live exception-carrying slot on the inputs.
    drive(1'b0, 1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 32'hCAFE_F00D, 7'h7F);
    step_check("reset0");
    drive(1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_0004, 1'b1, 32'd12, 32'h5555_AAAA, 7'd3);
    step_check("reset1");

    drive(1'b1, 1'b0, 1'b1, 2'd2, 32'd42, 1'b0, 32'd2, 32'h0000_0011, 7'd0);
    step_check("basic_load");
    drive(1'b0, 1'b0, 1'b1, 2'd1, 32'd4, 1'b1, 32'd12, 32'h0000_0055, 7'd3);
    step_check("reset_clears");
    drive(1'b1, 1'b0, 1'b0, 2'd3, 32'h100, 1'b1, 32'h0000_0BAD, 32'hDEAD_BEEF, 7'd9);
    step_check("invalid_slot");
    perturb_check("invalid_hold");

    // Back-to-back stream, inputs scrambled between edges.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 2'(i), 32'(8 + 4 * i), 1'(i == 1), 32'(100 + i),
            32'(32'hA000_0000 + i), 7'(i + 1));
      step_check($sformatf("stream%0d", i));
      perturb_check($sformatf("stream_hold%0d", i));
    end

    // Reset mid-stream drops the in-flight slot; the next non-reset edge loads normally.
    drive(1'b0, 1'b0, 1'b1, 2'd2, 32'd20, 1'b1, 32'd7, 32'h7777_7777, 7'd4);
    step_check("midstream_reset");
    drive(1'b1, 1'b0, 1'b1, 2'd1, 32'd24, 1'b1, 32'd8, 32'h8888_8888, 7'd5);
    step_check("after_reset");

`ifdef M_WB_STAGE_STALL_EN
    drive(1'b1, 1'b0, 1'b1, 2'd1, 32'd20, 1'b0, 32'd0, 32'h2020_2020, 7'd6);
    step_check("stall_pre");
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 2'd2, 32'd24, 1'b1, 32'd1, 32'h2424_2424, 7'd7);
      step_check($sformatf("stall_hold%0d", i));
    end
    drive(1'b1, 1'b0, 1'b1, 2'd2, 32'd24, 1'b1, 32'd1, 32'h2424_2424, 7'd7);
    step_check("stall_release");
    drive(1'b0, 1'b1, 1'b1, 2'd3, 32'd28, 1'b1, 32'd2, 32'h2828_2828, 7'd8);
    step_check("stall_reset");
`endif

    // Random traffic: occasional reset, mixed valid/exception, random stall.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom), 2'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
            7'($urandom));
      step_check($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
